// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: accepts one core request at a time,
// screens funct3 legality and alignment, runs a single-outstanding
// valid/ready bus transaction with a timeout, and returns a one-cycle
// response. Byte-lane formatting is delegated to the lsu block below.

// Byte-lane formatter: store data replication and write mask, plus load
// data extraction with sign/zero extension.
module lsu (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data_in,
  input  logic [31:0] load_data_in,
  output logic [31:0] STORE_data_out,
  output logic [3:0]  STORE_mask,
  output logic [31:0] LOAD_data_out
);

  logic [31:0]        ld_shift;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Store side: replicate the low byte/half across the word, mask the lanes
  always_comb begin
    STORE_data_out = store_data_in;
    STORE_mask     = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        STORE_data_out = {4{store_data_in[7:0]}};
        STORE_mask     = 4'b0001 << addr_lo;
      end
      2'b01: begin
        STORE_data_out = {2{store_data_in[15:0]}};
        STORE_mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        STORE_data_out = store_data_in;
        STORE_mask     = 4'b1111;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    ld_shift      = load_data_in >> {addr_lo, 3'b000};
    ld_byte       = ld_shift[7:0];
    ld_half       = ld_shift[15:0];
    LOAD_data_out = ld_shift;
    case (funct3)
      3'b000:  LOAD_data_out = 32'(ld_byte);
      3'b001:  LOAD_data_out = 32'(ld_half);
      3'b100:  LOAD_data_out = {24'd0, ld_shift[7:0]};
      3'b101:  LOAD_data_out = {16'd0, ld_shift[15:0]};
      default: LOAD_data_out = ld_shift;
    endcase
  end

endmodule

module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_F3    = 2'b10;
  localparam logic [1:0] ERR_TO    = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_addr_lo;

  logic [2:0]  fmt_funct3;
  logic [1:0]  fmt_addr_lo;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wmask;
  logic [31:0] fmt_rdata;

  // Loads: 011/110/111 reserved. Stores: only SB/SH/SW exist.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
  endfunction

  // The formatter sees the live request while idle (to build the store
  // lanes at accept) and the latched request afterwards (for load data).
  always_comb begin
    fmt_funct3  = (state == IDLE) ? req_funct3    : lat_funct3;
    fmt_addr_lo = (state == IDLE) ? req_addr[1:0] : lat_addr_lo;
  end

  lsu u_lsu (
    .funct3         (fmt_funct3),
    .addr_lo        (fmt_addr_lo),
    .store_data_in  (req_wdata),
    .load_data_in   (mem_rdata),
    .STORE_data_out (fmt_wdata),
    .STORE_mask     (fmt_wmask),
    .LOAD_data_out  (fmt_rdata)
  );

  // Controller FSM with registered handshake, bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_funct3  <= '0;
      lat_addr_lo <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= ERR_OK;
      resp_rdata  <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wmask   <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            lat_funct3  <= req_funct3;
            lat_addr_lo <= req_addr[1:0];
            req_ready   <= 1'b0;
            if (f3_illegal(req_is_store, req_funct3)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_F3;
              resp_rdata <= '0;
            end else if (misaligned(req_funct3, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ALIGN;
              resp_rdata <= '0;
            end else begin
              state     <= BUS;
              cnt       <= '0;
              mem_valid <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wmask <= req_is_store ? fmt_wmask : 4'b0000;
              mem_wdata <= req_is_store ? fmt_wdata : 32'd0;
            end
          end
        end
        BUS: begin
          if (mem_ready || (TO_EN && cnt == CNT_LAST)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= mem_ready ? ERR_OK : ERR_TO;
            resp_rdata <= (mem_ready && !mem_we) ? fmt_rdata : 32'd0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
